// File: rtl/lane_swizzle_pkg.sv
// Shared types and constants for the lane swizzle pipeline.
// The optional accept counter is enabled with LANE_SWIZZLE_STATS_EN.
package lane_swizzle_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic [1:0] {
    SWZ_PASS = 2'd0,
    SWZ_REV  = 2'd1,
    SWZ_SWAP = 2'd2,
    SWZ_ROTL = 2'd3
  } swz_mode_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // The counter sticks at all-ones instead of wrapping.
  function automatic logic [XFER_CNT_W-1:0] sat_inc(input logic [XFER_CNT_W-1:0] v);
    logic [XFER_CNT_W-1:0] r;
    if (v == {XFER_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + XFER_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_permute.sv
// Combinational lane permutation: pass, full reversal, pair swap, rotate-left by one lane.
module lane_permute
  import lane_swizzle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  input  swz_mode_e         i_mode,
  output logic [DATA_W-1:0] o_data
);

  localparam int NLANES = DATA_W / LANE_W;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    // Source lane of output lane gi for each mode; an odd top lane has no swap partner.
    localparam int REV_J = NLANES - 1 - gi;
    localparam int SWP_J = ((NLANES % 2 == 1) && (gi == NLANES - 1)) ? gi : (gi ^ 1);
    localparam int ROT_J = (gi == 0) ? (NLANES - 1) : (gi - 1);

    logic [LANE_W-1:0] w_lane;

    // Select the source lane for this output lane.
    always_comb begin
      w_lane = i_data[gi*LANE_W +: LANE_W];
      case (i_mode)
        SWZ_PASS: w_lane = i_data[gi*LANE_W +: LANE_W];
        SWZ_REV:  w_lane = i_data[REV_J*LANE_W +: LANE_W];
        SWZ_SWAP: w_lane = i_data[SWP_J*LANE_W +: LANE_W];
        SWZ_ROTL: w_lane = i_data[ROT_J*LANE_W +: LANE_W];
        default:  w_lane = i_data[gi*LANE_W +: LANE_W];
      endcase
    end

    assign o_data[gi*LANE_W +: LANE_W] = w_lane;
  end

endmodule

// File: rtl/lane_swizzle_pipe.sv
// Streaming lane permutation stage with output register plus skid register.
// Define LANE_SWIZZLE_STATS_EN to add the saturating xfer_count accept counter.
module lane_swizzle_pipe
  import lane_swizzle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef LANE_SWIZZLE_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_count
`endif
);

  skid_state_e       r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_or;
  logic [DATA_W-1:0] r_sk;

  logic [DATA_W-1:0] w_perm;
  logic              w_accept;
  logic              w_release;

  lane_permute #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_permute (
    .i_data (in_data),
    .i_mode (swz_mode_e'(in_mode)),
    .o_data (w_perm)
  );

  assign w_accept  = in_valid & r_in_ready;
  assign w_release = r_out_valid & out_ready;

  // Occupancy FSM; ready/valid are registered so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SKID_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_or        <= {DATA_W{1'b0}};
      r_sk        <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            r_or        <= w_perm;
            r_out_valid <= 1'b1;
            r_state     <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_accept && !w_release) begin
            r_sk       <= w_perm;
            r_in_ready <= 1'b0;
            r_state    <= SKID_TWO;
          end else if (w_accept && w_release) begin
            r_or <= w_perm;
          end else if (w_release) begin
            r_out_valid <= 1'b0;
            r_state     <= SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (w_release) begin
            r_or       <= r_sk;
            r_in_ready <= 1'b1;
            r_state    <= SKID_ONE;
          end
        end
        default: begin
          r_state     <= SKID_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_or;

`ifdef LANE_SWIZZLE_STATS_EN
  logic [XFER_CNT_W-1:0] r_xfer_count;

  // Saturating count of accepted words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count <= {XFER_CNT_W{1'b0}};
    end else if (w_accept) begin
      r_xfer_count <= sat_inc(r_xfer_count);
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_lane_swizzle_pipe.sv
// Randomised and directed bench for lane_swizzle_pipe against a queue-based reference model.
module tb_lane_swizzle_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  in_mode;

  logic        v2, rdy2, ov2, or2;
  logic [47:0] d2, od2;
  logic [1:0]  m2;

`ifdef LANE_SWIZZLE_STATS_EN
  logic [15:0] xfer_count, xfer_count2;
`endif

  always #5 clk = ~clk;

  lane_swizzle_pipe #(.DATA_W(32), .LANE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef LANE_SWIZZLE_STATS_EN
    , .xfer_count(xfer_count)
`endif
  );

  lane_swizzle_pipe #(.DATA_W(48), .LANE_W(16)) dut_odd (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_mode(m2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2)
`ifdef LANE_SWIZZLE_STATS_EN
    , .xfer_count(xfer_count2)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference permutation: for each output lane, pick its source lane by the mode rule.
  function automatic logic [63:0] model_perm(input logic [63:0] w, input int mode,
                                             input int nl, input int lw);
    logic [63:0] r;
    logic [63:0] mask;
    int j;
    r = 64'd0;
    mask = (64'd1 << lw) - 64'd1;
    for (int i = 0; i < nl; i++) begin
      case (mode)
        0: j = i;
        1: j = nl - 1 - i;
        2: j = ((nl % 2 == 1) && (i == nl - 1)) ? i : ((i % 2 == 0) ? i + 1 : i - 1);
        default: j = (i + nl - 1) % nl;
      endcase
      r = r | (((w >> (j * lw)) & mask) << (i * lw));
    end
    return r;
  endfunction

  // Model state: words in flight, oldest first, plus accept count.
  logic [31:0] mq[$];
  int acc_cnt = 0;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      acc_cnt = 0;
    end else begin
      if (out_valid && out_ready && mq.size() > 0) void'(mq.pop_front());
      if (in_valid && in_ready) begin
        mq.push_back(32'(model_perm({32'd0, in_data}, int'(in_mode), 4, 8)));
        acc_cnt++;
      end
    end
  end

  always begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
      if (mq.size() > 0) chk("out_data", {32'd0, out_data}, {32'd0, mq[0]});
`ifdef LANE_SWIZZLE_STATS_EN
      chk("xfer_count", {48'd0, xfer_count}, (acc_cnt > 65535) ? 64'd65535 : 64'(acc_cnt));
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  logic [31:0] exp_m [4] = '{32'h11223344, 32'h44332211, 32'h22114433, 32'h22334411};

  initial begin
    logic [31:0] w;
    logic [63:0] tmp;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; in_mode = 2'd0; out_ready = 1'b0;
    v2 = 1'b0; d2 = 48'd0; m2 = 2'd0; or2 = 1'b1;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Each mode on the reference word
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 32'h11223344; in_mode = 2'(m);
      @(posedge clk); #1;
      chk($sformatf("mode%0d_data", m), {32'd0, out_data}, {32'd0, exp_m[m]});
      chk($sformatf("mode%0d_valid", m), {63'd0, out_valid}, 64'd1);
    end
    @(negedge clk); in_valid = 1'b0;

    // Back-to-back stream with changing modes
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
      w = $urandom; in_valid = 1'b1; in_data = w; in_mode = 2'(k % 4);
      @(posedge clk); #1;
      chk("b2b_out", {32'd0, out_data}, model_perm({32'd0, w}, k % 4, 4, 8));
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: A, B fill both slots, C waits
    out_ready = 1'b0; in_mode = 2'd0;
    @(negedge clk); in_valid = 1'b1; in_data = 32'hA0A0A0A0;
    @(posedge clk); #1;
    chk("bp_a_ready", {63'd0, in_ready}, 64'd1);
    chk("bp_a_data", {32'd0, out_data}, 64'hA0A0A0A0);
    @(negedge clk); in_data = 32'hB1B1B1B1;
    @(posedge clk); #1;
    chk("bp_full_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk); in_data = 32'hC2C2C2C2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", {32'd0, out_data}, 64'hA0A0A0A0);
      chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_b_data", {32'd0, out_data}, 64'hB1B1B1B1);
    chk("bp_reopen", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("bp_c_data", {32'd0, out_data}, 64'hC2C2C2C2);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset while both slots are full
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = 32'hDEAD0001;
    @(negedge clk); in_data = 32'hDEAD0002;
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_data", {32'd0, out_data}, 64'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0BADF00D;
    @(posedge clk); #1;
    chk("arst_first", {32'd0, out_data}, 64'h0BADF00D);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("arst_alone", {63'd0, out_valid}, 64'd0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
      in_mode = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    t = 0;
    while (out_valid && t < 10) begin
      @(negedge clk); t++;
    end
    chk("drain", {63'd0, out_valid}, 64'd0);

    // Odd lane count instance
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      tmp = {$urandom, $urandom};
      if (k == 0) tmp = 64'h0000AAAABBBBCCCC;
      v2 = 1'b1; d2 = tmp[47:0]; m2 = 2'((k + 2) % 4);
      @(posedge clk); #1;
      chk("odd_valid", {63'd0, ov2}, 64'd1);
      chk("odd_data", {16'd0, od2}, model_perm({16'd0, tmp[47:0]}, (k + 2) % 4, 3, 16));
      if (k == 0) chk("odd_swap_lit", {16'd0, od2}, 64'h0000AAAACCCCBBBB);
    end
    @(negedge clk); v2 = 1'b0;

`ifdef LANE_SWIZZLE_STATS_EN
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b1;
    repeat (70000) @(negedge clk);
    chk("stats_sat", {48'd0, xfer_count}, 64'h000000000000FFFF);
    repeat (5) @(negedge clk);
    chk("stats_hold", {48'd0, xfer_count}, 64'h000000000000FFFF);
    in_valid = 1'b0;
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lane_swizzle_pipe.md
# lane_swizzle_pipe

Streaming lane-permutation stage: accepts words on a valid/ready input, applies a per-word lane permutation (pass, full reversal, pair swap, rotate), and presents the result on a valid/ready output after one register stage. It generalises the fixed 32-bit byte-reversal datapath to any word and lane width, with runtime mode selection. A two-entry skid buffer gives full throughput under backpressure. It sits on streaming datapaths between endianness-mismatched producers and consumers.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of LANE_W.
- LANE_W, 8, lane width in bits; NLANES = DATA_W/LANE_W, must be at least 2.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input word present.
- in_ready  output  1  stage can accept a word.
- in_data  input  DATA_W  input word; lane k is bits [k*LANE_W +: LANE_W].
- in_mode  input  2  permutation for this word, sampled with in_data.
- out_valid  output  1  output word present.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  permuted word.
- xfer_count  output  16  accepted-word count (only with LANE_SWIZZLE_STATS_EN).

## Operation
- Modes (out lane i from in lane j):
  - 0 PASS: i = j.
  - 1 REV: i = NLANES-1-j.
  - 2 SWAP: pairs (2m, 2m+1) exchanged; if NLANES is odd, the top lane passes unchanged.
  - 3 ROTL: out lane i+1 = in lane i; out lane 0 = in lane NLANES-1.
- The permutation is applied on the input side; registers hold already-permuted words.
- Storage is an output register (OR) plus a skid register (SK).
- States:
  - EMPTY: OR and SK both invalid.
  - ONE: OR valid, SK invalid.
  - TWO: OR and SK both valid.
- An accept is in_valid && in_ready. A release is out_valid && out_ready.
- Transitions:
  - EMPTY, accept -> ONE. The word loads into OR.
  - ONE, accept and no release -> TWO. The word loads into SK.
  - ONE, accept and release -> ONE. The word loads into OR.
  - ONE, release only -> EMPTY.
  - TWO, release -> ONE. SK moves to OR.
  - In TWO no accept is possible.
- in_ready = (state != TWO), driven from a register, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_data = OR.
- Words leave in acceptance order. None is dropped or duplicated.
- in_mode is a per-word field; a mode change between consecutive words needs no idle cycle.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, xfer_count = 0, state = EMPTY.
- Reset asserted mid-operation clears all stored words asynchronously. A word offered in the assertion cycle is lost.
- Latency: a word accepted at edge N is visible on out_data after edge N with out_valid = 1. This is 1 cycle.
- Throughput: 1 word/cycle while out_ready is held high.
- Backpressure: after two accepts with out_ready low, in_ready falls on the next cycle. With out_ready high it rises the cycle after the first release.
- Simultaneous accept and release in ONE keeps occupancy constant.
- out_data is stable while out_valid && !out_ready.

## Configuration
- LANE_SWIZZLE_STATS_EN defined:
  - xfer_count port exists.
  - It increments on every accept and saturates at 16'hFFFF, with no wrap.
- LANE_SWIZZLE_STATS_EN not defined: the port and counter logic are absent.

## Structure
- lane_swizzle_pkg contains:
  - the typedef enum logic [1:0] swz_mode_e {SWZ_PASS, SWZ_REV, SWZ_SWAP, SWZ_ROTL};
  - the typedef for the skid FSM state;
  - the constant XFER_CNT_W = 16.
- Sub-module lane_permute: purely combinational, parameterised by DATA_W/LANE_W, inputs data and mode, output permuted data. The top instantiates it once on the input side.

## Test plan
- DATA_W=32, LANE_W=8, out_ready=1. Feed 0x11223344 in each mode. Required outputs after 1 cycle:
  - PASS 0x11223344;
  - REV 0x44332211;
  - SWAP 0x22114433;
  - ROTL 0x22334411.
- Back-to-back stream of 8 words with alternating modes, out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, in_ready constantly 1.
- Feed A, B, C with out_ready=0 -> in_ready drops after B, C is held at input, out_data stays at A. Raise out_ready -> A, B, C delivered in order, none lost.
- Reset asserted while in TWO -> out_valid=0 and in_ready=1 immediately, before the next edge. After release, the first new word emerges alone.
- DATA_W=48, LANE_W=16 (odd NLANES), SWAP on 0xAAAABBBBCCCC -> 0xAAAACCCCBBBB (top lane unchanged).
- With LANE_SWIZZLE_STATS_EN: 70000 accepts -> xfer_count=0xFFFF and holds.
